dpram_fifo_ctrl: RTL and testbench

//  Upstream controller that turns the 8x8 dual-port RAM into a valid/ready FIFO.
//  RAM port A is the write port and RAM port B is the read port; port B is never written.

---
 rtl/dpram_fifo_if.sv | 23 ++
 rtl/dpram_fifo_ctrl.sv | 78 +++++++
 tb/tb_dpram_fifo_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dpram_fifo_if.sv
// Stream-side bundle of the dual-port-RAM FIFO controller: producer, consumer and occupancy.
interface dpram_fifo_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W:0]   count;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/dpram_fifo_ctrl.sv
// Valid/ready FIFO controller around an external 8x8 dual-port RAM (A = write, B = read).
// Keeps pointers, occupancy and handshakes; data lives only in the RAM.
module dpram_fifo_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    dpram_fifo_if.slave       bus,
    output logic              ram_wr_a,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic [DATA_W-1:0] ram_data_a,
    output logic              ram_wr_b,
    output logic [ADDR_W-1:0] ram_addr_b,
    output logic [DATA_W-1:0] ram_data_b,
    input  logic [DATA_W-1:0] ram_rdata_b
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [ADDR_W-1:0] wr_ptr, wr_ptr_next;
    logic [ADDR_W-1:0] rd_ptr, rd_ptr_next;
    logic [CNT_W-1:0]  count_q, count_next;
    logic              out_valid_q, out_valid_next;
    logic              in_ready_q, in_ready_next;
    logic              push, pop;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr_next;
            rd_ptr      <= rd_ptr_next;
            count_q     <= count_next;
            out_valid_q <= out_valid_next;
            in_ready_q  <= in_ready_next;
        end
    end

    // Next-state: handshakes, pointer advance, occupancy and output validity
    always_comb begin
        push           = 1'b0;
        pop            = 1'b0;
        wr_ptr_next    = wr_ptr;
        rd_ptr_next    = rd_ptr;
        count_next     = count_q;
        in_ready_next  = in_ready_q;
        out_valid_next = out_valid_q;

        push        = bus.in_valid & in_ready_q;
        pop         = out_valid_q & bus.out_ready;
        wr_ptr_next = wr_ptr + ADDR_W'(push);
        rd_ptr_next = rd_ptr + ADDR_W'(pop);
        count_next  = count_q + CNT_W'(push) - CNT_W'(pop);

        in_ready_next  = (count_next != CNT_W'(DEPTH));
        // A same-edge write/read of one address returns the old word, so hold off a cycle
        out_valid_next = (count_next != '0) & ~(push & (wr_ptr == rd_ptr_next));
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.count     = count_q;
    assign bus.out_data  = ram_rdata_b;

    assign ram_wr_a   = push;
    assign ram_addr_a = wr_ptr;
    assign ram_data_a = bus.in_data;
    assign ram_wr_b   = 1'b0;
    assign ram_data_b = '0;
    // Look-ahead read address so back-to-back pops see the next word without a bubble
    assign ram_addr_b = rd_ptr_next;
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl: models the RAM, checks against a queue-based FIFO reference.
module tb_dpram_fifo_ctrl;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DEPTH  = 8;

    typedef struct {
        logic [7:0] data;
        int         t;
    } entry_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ram_wr_a, ram_wr_b;
    logic [2:0] ram_addr_a, ram_addr_b;
    logic [7:0] ram_data_a, ram_data_b;
    logic [7:0] ram_rdata_b;
    logic [7:0] mem [DEPTH];

    dpram_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    dpram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .ram_wr_a   (ram_wr_a),
        .ram_addr_a (ram_addr_a),
        .ram_data_a (ram_data_a),
        .ram_wr_b   (ram_wr_b),
        .ram_addr_b (ram_addr_b),
        .ram_data_b (ram_data_b),
        .ram_rdata_b(ram_rdata_b)
    );

    always #5 clk = ~clk;

    // Dual-port RAM: registered read, old data on a same-address write/read collision
    always @(posedge clk) begin
        if (ram_wr_a) mem[ram_addr_a] <= ram_data_a;
        ram_rdata_b <= mem[ram_addr_b];
    end

    int     errors = 0;
    int     checks = 0;
    int     edge_n = 0;
    int     n_push = 0;
    int     n_pop  = 0;
    bit     m_rdy  = 1'b0;
    bit     m_vld  = 1'b0;
    entry_t q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One clock: check RAM-side drive, advance the reference model, check stream side
    task automatic cycle();
        bit     push, pop;
        entry_t e;
        #1;
        push = bus.in_valid && m_rdy;
        pop  = bus.out_ready && m_vld;
        chk("ram_wr_a", 32'(ram_wr_a), 32'(push));
        chk("ram_addr_b", 32'(ram_addr_b), 32'((n_pop + int'(pop)) % DEPTH));
        if (push) chk("ram_addr_a", 32'(ram_addr_a), 32'(n_push % DEPTH));
        @(posedge clk);
        edge_n++;
        if (pop) begin
            void'(q.pop_front());
            n_pop++;
        end
        if (push) begin
            e.data = bus.in_data;
            e.t    = edge_n;
            q.push_back(e);
            n_push++;
        end
        m_rdy = (q.size() != DEPTH);
        // Head is readable only once it was written before the latest edge
        m_vld = (q.size() > 0) && (q[0].t < edge_n);
        #1;
        chk("in_ready", 32'(bus.in_ready), 32'(m_rdy));
        chk("out_valid", 32'(bus.out_valid), 32'(m_vld));
        chk("count", 32'(bus.count), 32'(q.size()));
        if (m_vld) chk("out_data", 32'(bus.out_data), 32'(q[0].data));
    endtask

    task automatic model_reset();
        q.delete();
        n_push = 0;
        n_pop  = 0;
        m_rdy  = 1'b0;
        m_vld  = 1'b0;
    endtask

    task automatic reset_checks();
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_ram_wr_a", 32'(ram_wr_a), 32'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input string tag);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40 && q.size() > 0; i++) cycle();
        cycle();
        chk({tag, "_count"}, 32'(bus.count), 32'd0);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        model_reset();
        #2;
        reset_checks();
        release_reset();

        // 1: single write into empty, visible after two edges
        bus.in_valid = 1'b0;
        cycle();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        cycle();
        bus.in_valid = 1'b0;
        chk("t1_valid_e1", 32'(bus.out_valid), 32'd0);
        cycle();
        chk("t1_valid_e2", 32'(bus.out_valid), 32'd1);
        chk("t1_data", 32'(bus.out_data), 32'hA5);
        chk("t1_count", 32'(bus.count), 32'd1);
        drain("t1");

        // 2: fill, blocked push while full, full-rate drain
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            bus.in_data = 8'(i);
            cycle();
        end
        chk("t2_full_count", 32'(bus.count), 32'd8);
        chk("t2_full_ready", 32'(bus.in_ready), 32'd0);
        bus.in_data = 8'h09;
        for (int i = 0; i < 3; i++) cycle();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("t2_stream_valid", 32'(bus.out_valid), 32'd1);
            chk("t2_stream_data", 32'(bus.out_data), 32'(i));
            cycle();
        end
        chk("t2_empty_count", 32'(bus.count), 32'd0);
        chk("t2_empty_valid", 32'(bus.out_valid), 32'd0);

        // 3: push and pop together at count 1 -> one-cycle bubble
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h11;
        cycle();
        bus.in_valid = 1'b0;
        cycle();
        cycle();
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h22;
        bus.out_ready = 1'b1;
        cycle();
        chk("t3_bubble", 32'(bus.out_valid), 32'd0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        cycle();
        chk("t3_recover", 32'(bus.out_valid), 32'd1);
        chk("t3_data", 32'(bus.out_data), 32'h22);
        drain("t3");

        // 4: random traffic with stalls, pointers wrap several times
        for (int i = 0; i < 120; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_data   = 8'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            cycle();
            chk("t4_count_le8", 32'(bus.count <= 4'd8), 32'd1);
        end
        drain("t4");

        // 5: full, one pop reopens in_ready next cycle, late push comes out last
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_data = 8'(8'h40 + i);
            cycle();
        end
        chk("t5_full_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        cycle();
        chk("t5_ready_after_pop", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h99;
        cycle();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            chk("t5_order", 32'(bus.out_data), 32'(8'h40 + i));
            cycle();
        end
        chk("t5_last", 32'(bus.out_data), 32'h99);
        drain("t5");

        // 6: asynchronous reset with five entries held
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_data = 8'(8'h70 + i);
            cycle();
        end
        chk("t6_count5", 32'(bus.count), 32'd5);
        #3;
        rst_n = 1'b0;
        #1;
        reset_checks();
        model_reset();
        release_reset();
        bus.in_valid = 1'b0;
        cycle();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h3C;
        cycle();
        bus.in_valid = 1'b0;
        cycle();
        chk("t6_first_valid", 32'(bus.out_valid), 32'd1);
        chk("t6_first_data", 32'(bus.out_data), 32'h3C);
        drain("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
